// File: rtl/csel_pkg.sv
// Shared constants and types for the carry-select slice sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package csel_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the slice index; a single-slice build still needs one bit.
    function automatic int idx_w(input int slices);
        return (slices > 1) ? $clog2(slices) : 1;
    endfunction

endpackage

// File: rtl/csel_slice_sequencer_if.sv
// Operand-in / slice-out bundle for csel_slice_sequencer; ovf exists only with CSEL_OVF_EN.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the operand side, sl_valid/sl_ready on the slice side.
interface csel_slice_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             sl_valid;
    logic             sl_ready;
    logic [7:0]       sl_sum0;
    logic [7:0]       sl_sum1;
    logic             sl_sel;
    logic             sl_last;
    logic             cout;
    logic             cout_valid;
`ifdef CSEL_OVF_EN
    logic             ovf;
`endif

    // Environment side: offers operands, accepts slices.
    modport master (
        output in_valid, in_a, in_b, in_cin, sl_ready,
        input  in_ready, sl_valid, sl_sum0, sl_sum1, sl_sel, sl_last, cout, cout_valid
`ifdef CSEL_OVF_EN
        , input ovf
`endif
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_a, in_b, in_cin, sl_ready,
        output in_ready, sl_valid, sl_sum0, sl_sum1, sl_sel, sl_last, cout, cout_valid
`ifdef CSEL_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/csel_slice_pair.sv
// Conditional 8-bit adder pair: sum with carry-in 0 and with carry-in 1.
// Latency: combinational.
// Backpressure: none.
module csel_slice_pair (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum0,
    output logic       c0,
    output logic [7:0] sum1,
    output logic       c1
);

    // Both candidate sums as 9-bit results; bit 8 is the slice carry-out.
    always_comb begin
        {c0, sum0} = {1'b0, a} + {1'b0, b};
        {c1, sum1} = {1'b0, a} + {1'b0, b} + 9'd1;
    end

endmodule

// File: rtl/csel_slice_sequencer.sv
// Walks a WIDTH-bit operand pair LSB-first one 8-bit slice per cycle, presenting both conditional sums plus select; optional ovf output under CSEL_OVF_EN.
// Latency: accept at cycle 0, slice k in cycle k+1, cout_valid in cycle SLICES+1, ready again in SLICES+2.
// Backpressure: sl_ready low holds all slice outputs and state; operands only accepted in IDLE.
module csel_slice_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    csel_slice_sequencer_if.slave  bus
);
    import csel_pkg::*;

    localparam int             SLICES   = WIDTH / SLICE_W;
    localparam int             IW       = idx_w(SLICES);
    localparam logic [IW-1:0]  LAST_IDX = IW'(SLICES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IW-1:0]    idx_q;
    logic             cout_q;

    logic [7:0] sum0;
    logic [7:0] sum1;
    logic       c0;
    logic       c1;
    logic       run;
    logic       accept;
    logic       step;
    logic       last;
    logic       carry_nxt;
    logic       in_ready_c;
    logic       cout_valid_c;

    csel_slice_pair u_pair (
        .a    (a_q[7:0]),
        .b    (b_q[7:0]),
        .sum0 (sum0),
        .c0   (c0),
        .sum1 (sum1),
        .c1   (c1)
    );

    assign run       = (state == RUN);
    assign accept    = bus.in_valid && in_ready_c;
    assign step      = run && bus.sl_ready;
    assign last      = (idx_q == LAST_IDX);
    assign carry_nxt = carry_q ? c1 : c0;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs; DONE always lasts exactly one cycle.
    always_comb begin
        state_nxt    = state;
        in_ready_c   = 1'b0;
        cout_valid_c = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (bus.sl_ready && last) state_nxt = DONE;
            end
            DONE: begin
                cout_valid_c = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand shift registers, slice index and the carry chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.in_a;
            b_q     <= bus.in_b;
            carry_q <= bus.in_cin;
            idx_q   <= '0;
            cout_q  <= 1'b0;
        end else if (step) begin
            a_q     <= a_q >> SLICE_W;
            b_q     <= b_q >> SLICE_W;
            carry_q <= carry_nxt;
            idx_q   <= idx_q + IW'(1);
            if (last) cout_q <= carry_nxt;
        end
    end

`ifdef CSEL_OVF_EN
    logic ovf_q;
    logic [7:0] sel_sum;
    assign sel_sum = carry_q ? sum1 : sum0;

    // Signed overflow from the top slice: like-signed operands, result sign differs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                ovf_q <= 1'b0;
        else if (accept)        ovf_q <= 1'b0;
        else if (step && last)  ovf_q <= (a_q[7] == b_q[7]) && (sel_sum[7] != a_q[7]);
    end

    assign bus.ovf = ovf_q;
`endif

    // Slice outputs come from registers only and are blanked outside RUN.
    assign bus.in_ready   = in_ready_c;
    assign bus.sl_valid   = run;
    assign bus.sl_sum0    = run ? sum0 : 8'h00;
    assign bus.sl_sum1    = run ? sum1 : 8'h00;
    assign bus.sl_sel     = run && carry_q;
    assign bus.sl_last    = run && last;
    assign bus.cout       = cout_q;
    assign bus.cout_valid = cout_valid_c;

endmodule

// File: tb/tb_csel_slice_sequencer.sv
// Directed bench for csel_slice_sequencer at WIDTH=32; ovf checks compiled in with CSEL_OVF_EN.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises a 3-cycle sl_ready stall and in_valid held high during RUN/DONE.
module tb_csel_slice_sequencer;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    csel_slice_sequencer_if #(.WIDTH(32)) bus ();

    csel_slice_sequencer #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_slice(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                             input logic sel, input logic last);
        chk({tag, ".valid"}, 32'(bus.sl_valid), 32'd1);
        chk({tag, ".sum0"},  32'(bus.sl_sum0),  32'(s0));
        chk({tag, ".sum1"},  32'(bus.sl_sum1),  32'(s1));
        chk({tag, ".sel"},   32'(bus.sl_sel),   32'(sel));
        chk({tag, ".last"},  32'(bus.sl_last),  32'(last));
    endtask

    // Offer one operand pair in the current (IDLE) cycle; returns in cycle 1.
    task automatic start(input logic [31:0] a, input logic [31:0] b, input logic cin);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_cin   = 1'b0;
        bus.sl_ready = 1'b1;
        #12;
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst.in_ready",   32'(bus.in_ready),   32'd1);
        chk("rst.sl_valid",   32'(bus.sl_valid),   32'd0);
        chk("rst.sum0",       32'(bus.sl_sum0),    32'd0);
        chk("rst.sum1",       32'(bus.sl_sum1),    32'd0);
        chk("rst.sel",        32'(bus.sl_sel),     32'd0);
        chk("rst.last",       32'(bus.sl_last),    32'd0);
        chk("rst.cout",       32'(bus.cout),       32'd0);
        chk("rst.cout_valid", 32'(bus.cout_valid), 32'd0);

        // T1: 0xFF + 0x01, carry ripples into slice 1 only
        tick();
        start(32'h0000_00FF, 32'h0000_0001, 1'b0);
        chk("t1.in_ready", 32'(bus.in_ready), 32'd0);
        chk_slice("t1.s0", 8'h00, 8'h01, 1'b0, 1'b0); tick();
        chk_slice("t1.s1", 8'h00, 8'h01, 1'b1, 1'b0); tick();
        chk_slice("t1.s2", 8'h00, 8'h01, 1'b0, 1'b0); tick();
        chk_slice("t1.s3", 8'h00, 8'h01, 1'b0, 1'b1);
        chk("t1.c4.cout_valid", 32'(bus.cout_valid), 32'd0);
        tick();
        chk("t1.c5.cout_valid", 32'(bus.cout_valid), 32'd1);
        chk("t1.c5.cout",       32'(bus.cout),       32'd0);
        chk("t1.c5.in_ready",   32'(bus.in_ready),   32'd0);
        chk("t1.c5.sl_valid",   32'(bus.sl_valid),   32'd0);
        tick();
        chk("t1.c6.cout_valid", 32'(bus.cout_valid), 32'd0);
        chk("t1.c6.in_ready",   32'(bus.in_ready),   32'd1);

        // T3: same operands, slice 2 stalled for cycles 3..5
        start(32'h0000_00FF, 32'h0000_0001, 1'b0);
        chk_slice("t3.s0", 8'h00, 8'h01, 1'b0, 1'b0); tick();
        chk_slice("t3.s1", 8'h00, 8'h01, 1'b1, 1'b0); tick();
        bus.sl_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_slice($sformatf("t3.stall%0d", i), 8'h00, 8'h01, 1'b0, 1'b0);
            tick();
        end
        chk_slice("t3.s2", 8'h00, 8'h01, 1'b0, 1'b0);
        bus.sl_ready = 1'b1;
        tick();
        chk_slice("t3.s3", 8'h00, 8'h01, 1'b0, 1'b1);
        chk("t3.c7.cout_valid", 32'(bus.cout_valid), 32'd0);
        tick();
        chk("t3.c8.cout_valid", 32'(bus.cout_valid), 32'd1);
        chk("t3.c8.cout",       32'(bus.cout),       32'd0);
        tick();

        // T2: all-ones + 0 + cin=1, carry propagates through every slice
        start(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk_slice($sformatf("t2.s%0d", k), 8'hFF, 8'h00, 1'b1, (k == 3));
            tick();
        end
        chk("t2.cout_valid", 32'(bus.cout_valid), 32'd1);
        chk("t2.cout",       32'(bus.cout),       32'd1);
        tick();
        chk("t2.hold.cout",  32'(bus.cout),       32'd1);

        // T4: reset while slice 1 is presented
        start(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        chk_slice("t4.s0", 8'hFF, 8'h00, 1'b1, 1'b0);
        tick();
        chk_slice("t4.s1", 8'hFF, 8'h00, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("t4.async.sl_valid", 32'(bus.sl_valid), 32'd0);
        chk("t4.async.in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        rst = 1'b0;
        chk("t4.cout", 32'(bus.cout), 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t4.c%0d.cout_valid", i), 32'(bus.cout_valid), 32'd0);
            chk($sformatf("t4.c%0d.sl_valid", i),   32'(bus.sl_valid),   32'd0);
            tick();
        end

        // T5: in_valid held high with changing operands during RUN and DONE
        start(32'h1234_5678, 32'h1111_1111, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_a = 32'hDEAD_0001; bus.in_b = 32'hBEEF_0001; bus.in_cin = 1'b1;
        chk_slice("t5.s0", 8'h89, 8'h8A, 1'b0, 1'b0); tick();
        bus.in_a = 32'hDEAD_0002; bus.in_b = 32'hBEEF_0002;
        chk_slice("t5.s1", 8'h67, 8'h68, 1'b0, 1'b0); tick();
        bus.in_a = 32'hDEAD_0003; bus.in_b = 32'hBEEF_0003;
        chk_slice("t5.s2", 8'h45, 8'h46, 1'b0, 1'b0); tick();
        bus.in_a = 32'hDEAD_0004; bus.in_b = 32'hBEEF_0004;
        chk_slice("t5.s3", 8'h23, 8'h24, 1'b0, 1'b1); tick();
        bus.in_a = 32'hDEAD_0005; bus.in_b = 32'hBEEF_0005;
        chk("t5.done.in_ready",   32'(bus.in_ready),   32'd0);
        chk("t5.done.cout_valid", 32'(bus.cout_valid), 32'd1);
        chk("t5.done.cout",       32'(bus.cout),       32'd0);
        tick();
        chk("t5.idle.in_ready",   32'(bus.in_ready),   32'd1);
        bus.in_a = 32'h8000_0000; bus.in_b = 32'h8000_0000; bus.in_cin = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk_slice("t5b.s0", 8'h00, 8'h01, 1'b1, 1'b0); tick();
        chk_slice("t5b.s1", 8'h00, 8'h01, 1'b0, 1'b0); tick();
        chk_slice("t5b.s2", 8'h00, 8'h01, 1'b0, 1'b0); tick();
        chk_slice("t5b.s3", 8'h00, 8'h01, 1'b0, 1'b1); tick();
        chk("t5b.cout_valid", 32'(bus.cout_valid), 32'd1);
        chk("t5b.cout",       32'(bus.cout),       32'd1);
`ifdef CSEL_OVF_EN
        chk("t5b.ovf",        32'(bus.ovf),        32'd1);
`endif
        tick();

        // T6: signed overflow cases
        start(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        chk_slice("t6a.s3pre", 8'h00, 8'h01, 1'b0, 1'b0);
        tick(); tick(); tick(); tick();
        chk("t6a.cout_valid", 32'(bus.cout_valid), 32'd1);
        chk("t6a.cout",       32'(bus.cout),       32'd0);
`ifdef CSEL_OVF_EN
        chk("t6a.ovf",        32'(bus.ovf),        32'd1);
`endif
        tick();
        start(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        tick(); tick(); tick(); tick();
        chk("t6b.cout_valid", 32'(bus.cout_valid), 32'd1);
        chk("t6b.cout",       32'(bus.cout),       32'd1);
`ifdef CSEL_OVF_EN
        chk("t6b.ovf",        32'(bus.ovf),        32'd0);
`endif
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csel_slice_sequencer.md
# csel_slice_sequencer

Upstream feeder for the 8-bit carry-select sum multiplexer stage. Accepts a WIDTH-bit operand pair plus carry-in over a valid/ready handshake, walks the operands one 8-bit slice per cycle LSB-first, and presents both conditional slice sums (carry-in 0 and 1) with the select bit that the downstream multiplexer uses to pick between them. Tracks the inter-slice carry internally and reports the final carry-out.

## Interface
- WIDTH, 32, operand width; multiple of 8, ≥ 8; SLICES = WIDTH/8
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  operand pair offered
- in_ready  output  1  high only in IDLE
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry-in
- sl_valid  output  1  slice data valid; high only in RUN
- sl_ready  input  1  downstream accepts slice
- sl_sum0  output  8  slice sum assuming carry-in 0
- sl_sum1  output  8  slice sum assuming carry-in 1
- sl_sel  output  1  actual carry into this slice; downstream selects sl_sum1 when 1
- sl_last  output  1  current slice is slice SLICES-1
- cout  output  1  final carry-out; held until next accept
- cout_valid  output  1  one-cycle pulse with new cout

## Operation
- FSM states IDLE, RUN, DONE. Reset → IDLE; operand shift registers, slice counter, carry register, cout all 0.
- IDLE: in_ready=1. On in_valid&&in_ready: latch in_a/in_b into shift registers, carry_reg←in_cin, idx←0, cout←0, → RUN.
- RUN: sl_valid=1. sl_sum0/sl_c0 = a[7:0]+b[7:0]; sl_sum1/sl_c1 = a[7:0]+b[7:0]+1 (9-bit results, carry = bit 8). sl_sel=carry_reg. sl_last = (idx==SLICES-1).
- On sl_valid&&sl_ready: carry_reg ← sl_sel ? c1 : c0; shift operands right 8; idx++. If sl_last: cout ← next carry, → DONE.
- sl_ready low: all slice outputs and state held stable.
- DONE: cout_valid=1 for exactly one cycle, in_ready=0; → IDLE unconditionally.
- in_valid outside IDLE ignored; operands not sampled.
- Slice outputs are functions of internal registers only; no input-to-output combinational path (sl_ready affects only next state).
- Reset mid-operation: immediate return to IDLE, transaction abandoned, no cout_valid, cout cleared.
- WIDTH=8: single slice, sl_last high on the only slice.

## Timing
- Accept at edge of cycle 0 → slice k presented from cycle k+1 (no backpressure) → cout_valid in cycle SLICES+1 → in_ready high in cycle SLICES+2.
- Throughput: one transaction per SLICES+2 cycles minimum.
- Each stall cycle (sl_ready=0) delays all later events by one cycle.
- Reset values: in_ready=1, sl_valid=0, sl_sum0=sl_sum1=0 (operand regs 0; sl_sum1 decoded only when sl_valid), sl_sel=0, sl_last=0, cout=0, cout_valid=0.

## Configuration
- CSEL_OVF_EN defined: extra output ovf (1 bit), signed overflow of the full add, = (a_msb==b_msb) && (selected final-slice sum MSB ≠ a_msb); updated and held with cout, reset 0.
- Not defined: ovf port and its logic absent; all other behaviour identical.

## Structure
- Package csel_pkg: SLICE_W=8 constant, state enum {IDLE, RUN, DONE}, slice-count/index width function.
- One sub-module csel_slice_pair: combinational 8-bit conditional adder pair producing sum0, c0, sum1, c1.

## Test plan
- WIDTH=32, a=0x000000FF, b=0x00000001, cin=0, sl_ready=1 → slice0 sum0=0x00 sum1=0x01 sel=0; slice1 sum0=0x00 sum1=0x01 sel=1; slices 2–3 sel=0; cout=0, cout_valid in cycle 5 only.
- a=0xFFFFFFFF, b=0, cin=1 → every slice sum0=0xFF sum1=0x00 sel=1; cout=1.
- Same as first, sl_ready low 3 cycles on slice 2 → sl_sum0/sl_sum1/sl_sel/sl_last stable throughout, cout_valid in cycle 8.
- rst asserted while slice 1 presented → next cycle IDLE, sl_valid=0, in_ready=1, no cout_valid, cout=0.
- in_valid held high with changing operands during RUN/DONE → ignored; second transaction accepted only in IDLE, results match second operands.
- CSEL_OVF_EN: a=0x7FFFFFFF, b=0x00000001, cin=0 → ovf=1, cout=0; a=0xFFFFFFFF, b=1 → ovf=0, cout=1.
